seq_player: RTL and testbench
=============================

// Module: seq_player
// PURPOSE
//   Reads a captured 64-bit round sequence and plays it back as 4-bit symbols, MSB nibble first.
//   Each symbol is held for HOLD_CYCLES clocks, followed by GAP_CYCLES blank clocks.
//   Sits between the sequence register (writer side) and the LED/display driver.
//   Presents the current round's pattern to the player before input is compared.
// PARAMETERS
//   HOLD_CYCLES  50_000_000  clocks each symbol is shown (>=1)
//   GAP_CYCLES   12_500_000  blank clocks between consecutive symbols (>=1)
// PORTS
//   clk        in   1   clock; all logic on rising edge
//   R          in   1   reset, synchronous, active-low
//   start      in   1   request playback; sampled only in IDLE
//   round      in   5   symbols to play, 0..16; values >16 clamp to 16
//   seq        in   64  sequence; symbol i = seq[63-4i -: 4]
//   sym        out  4   current symbol; 4'h0 when not showing
//   sym_valid  out  1   high while sym carries a symbol
//   busy       out  1   high in any state except IDLE
//   done       out  1   one-cycle pulse at end of playback
// BEHAVIOUR
//   Reset (R==0 at a clock edge): state=IDLE; sym=0, sym_valid=0, busy=0, done=0; counters and index cleared.
//   Reset mid-playback aborts immediately. No done pulse is issued.
//   FSM states: IDLE, SHOW, GAP, DONE.
//   IDLE: on start=1, snapshot seq and clamped round into internal registers; later seq changes are ignored.
//     round==0: go to DONE (no symbols shown). Otherwise go to SHOW with idx=0 and timer=0.
//   SHOW: sym=snap[63-4*idx -: 4], sym_valid=1. After HOLD_CYCLES clocks:
//     if idx==round-1, go to DONE; else go to GAP.
//   GAP: sym=0, sym_valid=0 for GAP_CYCLES clocks, then idx++ and go to SHOW.
//   DONE: done=1 for exactly one cycle, then go to IDLE.
//   Latency: start accepted at edge t; first sym_valid starts at t+1.
//     done is asserted at t+1 + N*HOLD_CYCLES + (N-1)*GAP_CYCLES (N = clamped round).
//     With round==0, done is asserted at t+1.
//   start while busy: ignored, no queuing. start high in the same cycle done is high: ignored; it is accepted only in IDLE.
//   Outputs are registered. sym and sym_valid change only on state/index transitions.
//   Timer width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). idx is 4 bits and never wraps past round-1.
// CONFIGURATION
//   SEQ_PLAYER_PAUSE_EN defined: adds input port pause (1 bit, after seq).
//     While pause=1 in SHOW or GAP, the timer, idx, state and outputs are frozen.
//     pause has no effect in IDLE or DONE. Reset overrides pause.
//   Not defined: no pause port; playback runs uninterrupted.
// STRUCTURE
//   Package seq_pkg: SEQ_W=64, SYM_W=4, MAX_SYM=16, and the state encoding (IDLE=2'd0, SHOW=2'd1, GAP=2'd2, DONE=2'd3).
//     The sequence register and the input checker share this package.
//   Sub-module seq_hold_timer: loadable down-counter with expire flag and freeze input.
//     One instance serves both SHOW and GAP, reloaded on each transition.
// TESTING  (bench uses HOLD_CYCLES=4, GAP_CYCLES=2)
//   Reset: hold R=0 for 3 clocks with start=1 -> all outputs 0, busy=0 throughout.
//   seq=64'h1248_0000_0000_0000, round=3, start pulse at t=0:
//     -> sym=1 on cycles 1-4, 0 on 5-6, 2 on 7-10, 0 on 11-12, 4 on 13-16; done=1 at 17 only.
//   round=0, start -> no sym_valid; done=1 at t+1; busy=1 for that cycle only.
//   round=20 with seq=64'h1111_..._1111 -> exactly 16 symbols; done at t+1+16*4+15*2 = t+95.
//   Change seq and pulse start mid-playback -> output still follows the snapshot; second start ignored.
//   Drop R at cycle 8 of round=3 playback -> next cycle IDLE with outputs 0 and no done pulse.
//     A following start plays from symbol 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the round-sequence blocks: widths, symbol limits,
// FSM state encoding and small helpers used by the player and its neighbours.
package seq_pkg;

    localparam int SEQ_W   = 64;
    localparam int SYM_W   = 4;
    localparam int MAX_SYM = 16;
    localparam int RND_W   = 5;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Requests for more symbols than the sequence holds play the whole sequence.
    function automatic logic [RND_W-1:0] clamp_round(input logic [RND_W-1:0] r);
        return (r > RND_W'(MAX_SYM)) ? RND_W'(MAX_SYM) : r;
    endfunction

    // Symbol i is the i-th nibble counting from the MSB end.
    function automatic logic [SYM_W-1:0] pick_sym(input logic [SEQ_W-1:0] s,
                                                   input logic [IDX_W-1:0] i);
        logic [SEQ_W-1:0] shifted;
        shifted = s << {i, 2'b00};
        return shifted[SEQ_W-1 -: SYM_W];
    endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases of seq_player.
// expired is high while the count sits at zero; freeze holds the count.
module seq_hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         R,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         freeze,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (!R) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!freeze && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/seq_player.sv
// Plays a snapshot of the 64-bit round sequence as 4-bit symbols, MSB first,
// with HOLD/GAP timing. Optional SEQ_PLAYER_PAUSE_EN adds a pause input.
module seq_player
    import seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [RND_W-1:0] round,
    input  logic [SEQ_W-1:0] seq,
`ifdef SEQ_PLAYER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    // The timer expires at zero, so loading N-1 yields a phase of exactly N clocks.
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SEQ_W-1:0] snap_q, snap_d;
    logic [RND_W-1:0] round_q, round_d;

    logic [SYM_W-1:0] sym_d;
    logic             sym_valid_d;
    logic             busy_d;
    logic             done_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             hold;

`ifdef SEQ_PLAYER_PAUSE_EN
    assign hold = pause && (state_q == SHOW || state_q == GAP);
`else
    assign hold = 1'b0;
`endif

    seq_hold_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .R        (R),
        .load     (tmr_load),
        .load_val (tmr_val),
        .freeze   (hold),
        .expired  (tmr_expired)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        round_d  = round_q;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = seq;
                    round_d = clamp_round(round);
                    idx_d   = '0;
                    if (round_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end
                end
            end
            SHOW: begin
                if (!hold && tmr_expired) begin
                    if ({1'b0, idx_q} == round_q - RND_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (!hold && tmr_expired) begin
                    idx_d    = idx_q + 1'b1;
                    state_d  = SHOW;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the upcoming state.
        sym_d       = (state_d == SHOW) ? pick_sym(snap_d, idx_d) : '0;
        sym_valid_d = (state_d == SHOW);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            round_q   <= '0;
            sym       <= '0;
            sym_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            round_q   <= round_d;
            sym       <= sym_d;
            sym_valid <= sym_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with HOLD_CYCLES=4, GAP_CYCLES=2.
// Cycle c of a playback is the clock period following edge c-1 (start sampled at edge 0).
module tb_seq_player;
    import seq_pkg::*;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic             clk   = 1'b0;
    logic             R     = 1'b0;
    logic             start = 1'b0;
    logic [RND_W-1:0] round = '0;
    logic [SEQ_W-1:0] seq   = '0;
`ifdef SEQ_PLAYER_PAUSE_EN
    logic             pause = 1'b0;
`endif
    logic [SYM_W-1:0] sym;
    logic             sym_valid;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_player #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .R         (R),
        .start     (start),
        .round     (round),
        .seq       (seq),
`ifdef SEQ_PLAYER_PAUSE_EN
        .pause     (pause),
`endif
        .sym       (sym),
        .sym_valid (sym_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected symbol for seq=1248_0000..., round=3.
    function automatic logic [3:0] exp_1248(input int c);
        if (c >= 1 && c <= 4)   return 4'h1;
        if (c >= 7 && c <= 10)  return 4'h2;
        if (c >= 13 && c <= 16) return 4'h4;
        return 4'h0;
    endfunction

    // Called at a negedge; start is sampled at the next rising edge (edge 0).
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " sym"},       64'(sym),       64'h0);
        check({tag, " sym_valid"}, 64'(sym_valid), 64'h0);
        check({tag, " busy"},      64'(busy),      64'h0);
        check({tag, " done"},      64'(done),      64'h0);
    endtask

    task automatic run_1248(input string tag);
        logic [3:0] e;
        seq   = 64'h1248_0000_0000_0000;
        round = 5'd3;
        start_pulse();
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            e = exp_1248(c);
            check($sformatf("%s sym@%0d", tag, c),   64'(sym),       64'(e));
            check($sformatf("%s valid@%0d", tag, c), 64'(sym_valid), 64'(e != 4'h0));
            check($sformatf("%s done@%0d", tag, c),  64'(done),      64'(c == 17));
            check($sformatf("%s busy@%0d", tag, c),  64'(busy),      64'(c <= 17));
        end
    endtask

    initial begin
        // Reset held for three clocks with start asserted.
        R     = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("reset%0d", i));
        end
        start = 1'b0;
        R     = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_1248("play3");

        // round == 0: single DONE cycle, nothing shown.
        round = 5'd0;
        start_pulse();
        @(negedge clk);
        check("r0 done@1",  64'(done),      64'h1);
        check("r0 busy@1",  64'(busy),      64'h1);
        check("r0 valid@1", 64'(sym_valid), 64'h0);
        @(negedge clk);
        check("r0 done@2",  64'(done),      64'h0);
        check("r0 busy@2",  64'(busy),      64'h0);

        // round > 16 clamps to 16 symbols.
        begin
            int   valid_cnt = 0;
            int   starts    = 0;
            int   bad_sym   = 0;
            int   done_at   = -1;
            logic prev_v    = 1'b0;
            seq   = {16{4'h1}};
            round = 5'd20;
            start_pulse();
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (sym_valid) begin
                    valid_cnt++;
                    if (!prev_v) starts++;
                    if (sym != 4'h1) bad_sym++;
                end
                if (done && done_at < 0) done_at = c;
                prev_v = sym_valid;
                if (done_at >= 0 && c > done_at + 2) break;
            end
            check("r20 symbols",     64'(starts),    64'd16);
            check("r20 valid_cycles", 64'(valid_cnt), 64'd64);
            check("r20 bad_sym",     64'(bad_sym),   64'd0);
            check("r20 done_cycle",  64'(done_at),   64'd95);
        end

        // Snapshot: seq change and extra start mid-playback are ignored.
        seq   = 64'hABCD_0000_0000_0000;
        round = 5'd2;
        start_pulse();
        for (int c = 1; c <= 13; c++) begin
            logic [3:0] e;
            @(negedge clk);
            e = (c >= 1 && c <= 4) ? 4'hA : (c >= 7 && c <= 10) ? 4'hB : 4'h0;
            check($sformatf("snap sym@%0d", c),  64'(sym),  64'(e));
            check($sformatf("snap done@%0d", c), 64'(done), 64'(c == 11));
            check($sformatf("snap busy@%0d", c), 64'(busy), 64'(c <= 11));
            if (c == 3) begin
                seq   = {16{4'hF}};
                start = 1'b1;
            end
            if (c == 4) start = 1'b0;
        end

        // Reset mid-playback aborts with no done pulse.
        seq   = 64'h1248_0000_0000_0000;
        round = 5'd3;
        start_pulse();
        for (int c = 1; c <= 8; c++) @(negedge clk);
        check("abort sym@8", 64'(sym), 64'h2);
        R = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort@9");
        R = 1'b1;
        begin
            int done_cnt = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check("abort no_done", 64'(done_cnt), 64'd0);
        end

        run_1248("replay");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
